// File: rtl/pp_input_conditioner.sv
// Button synchroniser/debouncer, press-flag latch and step tick for pong.
// Define PP_SPEEDUP_EN to shrink the step period on each returned ball.
module pp_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_DIV        = 25000000,
  parameter int unsigned TICK_MIN        = 6250000,
  parameter int unsigned TICK_STEP       = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn0_raw,
  input  logic btn1_raw,
  input  logic rally_clr,
  output logic D,
  output logic P0,
  output logic P1
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TW = $clog2(TICK_DIV + 1);

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] PER_BASE =
    TW'(TICK_DIV);

  logic [1:0]         raw;
  logic [1:0]         s1_q;
  logic [1:0]         s2_q;
  logic [1:0]         lvl_q;
  logic [1:0]         lvl_d;
  logic [1:0][DW-1:0] dbc_q;
  logic [1:0][DW-1:0] dbc_d;
  logic [1:0]         press;
  logic [1:0]         flag_q;
  logic [1:0]         flag_d;
  logic [TW-1:0]      cnt_q;
  logic [TW-1:0]      cnt_d;
  logic [TW-1:0]      period;
  logic               d_q;
  logic               d_d;

  assign raw = {btn1_raw, btn0_raw};

  // two-flop synchroniser for the raw buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // accept a new level only after an unbroken run of mismatches
  always_comb begin
    lvl_d = lvl_q;
    dbc_d = dbc_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          lvl_d[i] = s2_q[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + DW'(1);
        end
      end else begin
        dbc_d[i] = '0;
      end
    end
  end

  assign press = ~lvl_q & lvl_d;

  // a step consumes the flag; a press on that same edge re-arms it
  always_comb begin
    flag_d = flag_q | press;
    if (d_q) begin
      flag_d = press;
    end
  end

  // debounced levels, counters and press flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q  <= '0;
      dbc_q  <= '0;
      flag_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      dbc_q  <= dbc_d;
      flag_q <= flag_d;
    end
  end

  // >= so a period shrinking below cnt fires at once
  always_comb begin
    cnt_d = cnt_q + TW'(1);
    d_d   = 1'b0;
    if (cnt_q >= period - TW'(1)) begin
      cnt_d = '0;
      d_d   = 1'b1;
    end
  end

  // step tick counter and registered step enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      d_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      d_q   <= d_d;
    end
  end

`ifdef PP_SPEEDUP_EN
  localparam logic [32:0] FLOOR =
    33'(TICK_MIN) + 33'(TICK_STEP);

  logic [TW-1:0] period_q;
  logic [TW-1:0] period_d;

  // rally end restores base speed and beats a same-edge shrink
  always_comb begin
    period_d = period_q;
    if (rally_clr) begin
      period_d = PER_BASE;
    end else if (d_q && (flag_q != 2'b00)) begin
      if (33'(period_q) >= FLOOR) begin
        period_d = period_q - TW'(TICK_STEP);
      end else begin
        period_d = TW'(TICK_MIN);
      end
    end
  end

  // current step period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q <= PER_BASE;
    end else begin
      period_q <= period_d;
    end
  end

  assign period = period_q;
`else
  logic unused_rally;

  assign period       = PER_BASE;
  assign unused_rally = rally_clr;
`endif

  assign D  = d_q;
  assign P0 = flag_q[0];
  assign P1 = flag_q[1];

endmodule

// File: tb/tb_pp_input_conditioner.sv
// Scoreboarded bench for pp_input_conditioner.
// Expected step edges differ when PP_SPEEDUP_EN is defined.
module tb_pp_input_conditioner;

  logic clk       = 1'b0;
  logic reset     = 1'b0;
  logic btn0_raw  = 1'b0;
  logic btn1_raw  = 1'b0;
  logic rally_clr = 1'b0;
  logic D;
  logic P0;
  logic P1;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  typedef struct {
    int   e;
    logic p0;
    logic p1;
  } exp_t;

  exp_t q[$];
  exp_t mx;

`ifdef PP_SPEEDUP_EN
  localparam int RST_AT = 161;
`else
  localparam int RST_AT = 166;
`endif

  pp_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(10),
    .TICK_MIN(4),
    .TICK_STEP(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn0_raw(btn0_raw),
    .btn1_raw(btn1_raw),
    .rally_clr(rally_clr),
    .D(D),
    .P0(P0),
    .P1(P1)
  );

  always #5 clk = ~clk;

  // edges since the latest reset release
  always @(posedge clk or negedge reset) begin
    if (!reset) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d (edge %0d)",
               nm, act, exp, edge_n);
    end
  endtask

  task automatic push(input int e,
                      input logic p0,
                      input logic p1);
    exp_t x;
    x.e  = e;
    x.p0 = p0;
    x.p1 = p1;
    q.push_back(x);
  endtask

  // land just after the negedge following edge n
  task automatic at(input int n);
    while (edge_n < n) @(negedge clk);
    #1;
  endtask

  // monitor: every step pulse must match the next expectation
  always @(negedge clk) begin
    if (D === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL D_unexpected: pulse at edge %0d",
                 edge_n);
      end else begin
        mx = q.pop_front();
        chk("D_edge", edge_n, mx.e);
        chk("D_P0", 32'(P0), 32'(mx.p0));
        chk("D_P1", 32'(P1), 32'(mx.p1));
      end
    end
  end

  initial begin
    for (int e = 10; e <= 110; e += 10)
      push(e, e == 50 || e == 100, e == 70);
`ifdef PP_SPEEDUP_EN
    push(120, 1'b0, 1'b1);
    push(127, 1'b1, 1'b0);
    push(131, 1'b0, 1'b1);
    push(135, 1'b0, 1'b0);
    push(145, 1'b0, 1'b0);
    push(155, 1'b0, 1'b0);
`else
    push(120, 1'b0, 1'b1);
    push(130, 1'b1, 1'b1);
    push(140, 1'b0, 1'b0);
    push(150, 1'b0, 1'b0);
    push(160, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("rst_D", 32'(D), 0);
      chk("rst_P0", 32'(P0), 0);
      chk("rst_P1", 32'(P1), 0);
    end
    reset = 1'b1;

    at(31); btn0_raw = 1'b1;
    at(33); btn0_raw = 1'b0;
    at(35); btn0_raw = 1'b1;
    at(37); btn0_raw = 1'b0;
    at(39); btn0_raw = 1'b1;
    at(44); chk("db_early_P0", 32'(P0), 0);
    at(45); chk("db_rise_P0", 32'(P0), 1);
    at(50); rally_clr = 1'b1;
    at(51); rally_clr = 1'b0;
    chk("consume_P0", 32'(P0), 0);
    at(52); btn0_raw = 1'b0;

    at(55); btn1_raw = 1'b1;
    at(62); chk("coinc_hold_P1", 32'(P1), 1);
    at(70); rally_clr = 1'b1;
    at(71); rally_clr = 1'b0;
    chk("coinc_consume_P1", 32'(P1), 0);
    at(72); btn1_raw = 1'b0;

    at(85); btn0_raw = 1'b1;
    at(89); btn0_raw = 1'b0;
    at(92); chk("two_first_P0", 32'(P0), 1);
    at(93); btn0_raw = 1'b1;
    at(100); rally_clr = 1'b1;
    at(101); rally_clr = 1'b0;
    btn0_raw = 1'b0;
    chk("two_consume_P0", 32'(P0), 0);

    at(109); btn1_raw = 1'b1;
    at(115); btn1_raw = 1'b0;
    at(119); btn0_raw = 1'b1;
    at(123); btn1_raw = 1'b1;
    at(135); rally_clr = 1'b1;
    at(136); rally_clr = 1'b0;
    at(139); btn0_raw = 1'b0;
    btn1_raw = 1'b0;

    at(155); btn1_raw = 1'b1;
    at(RST_AT);
    chk("mid_latched_P1", 32'(P1), 1);
    reset    = 1'b0;
    btn1_raw = 1'b0;
    #1;
    chk("mid_rst_P1", 32'(P1), 0);
    chk("mid_rst_D", 32'(D), 0);
    chk("seg1_drained", q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;

    push(10, 1'b0, 1'b0);
    push(20, 1'b0, 1'b0);
    at(21);
    chk("seg2_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
